// File: rtl/fpu_div16.sv
// Sequential binary16 divider: fpuOut = fpuIn1 / fpuIn2, restoring significand division
// with round-to-nearest-even, start/done handshake, condition codes and IEEE status flags.
module fpu_div16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] fpuIn1,
    input  logic [15:0] fpuIn2,
    output logic [15:0] fpuOut,
    output logic        done,
    output logic [3:0]  condCodes,
    output logic [4:0]  opStatusFlags
);
    localparam int EXPW  = 5;
    localparam int FRACW = 10;
    localparam int BIAS  = 15;
    localparam int QBITS = 13;
    localparam int EW    = EXPW + 3;
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIVIDE, S_ROUND, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            a_q, a_d, b_q, b_d;
    logic [FRACW:0]         sig1_q, sig1_d, sig2_q, sig2_d;
    logic signed [EW-1:0]   ex1_q, ex1_d, ex2_q, ex2_d, exp_q, exp_d;
    logic [FRACW+1:0]       rem_q, rem_d;
    logic [QBITS-1:0]       quo_q, quo_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            out_q, out_d;
    logic [4:0]             flags_q, flags_d;
    logic [3:0]             cc_q, cc_d;

    function automatic logic [3:0] cc_of(input logic [15:0] v);
        return {v[14:0] == 15'd0, 1'b0, v[15], 1'b0};
    endfunction

    // Operand classification on the latched operands
    logic nan1, nan2, inf1, inf2, zero1, zero2, sign_r;
    assign nan1   = (&a_q[14:10]) && (|a_q[9:0]);
    assign nan2   = (&b_q[14:10]) && (|b_q[9:0]);
    assign inf1   = (&a_q[14:10]) && !(|a_q[9:0]);
    assign inf2   = (&b_q[14:10]) && !(|b_q[9:0]);
    assign zero1  = a_q[14:0] == 15'd0;
    assign zero2  = b_q[14:0] == 15'd0;
    assign sign_r = a_q[15] ^ b_q[15];

    logic        special;
    logic [15:0] spec_res;
    logic [4:0]  spec_flags;

    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_res   = 16'h7E00;
            spec_flags = 5'b10000;
        end else if (zero2 && !inf1) begin
            spec_res   = {sign_r, 5'h1F, 10'h0};
            spec_flags = 5'b01000;
        end else if (inf1) begin
            spec_res   = {sign_r, 5'h1F, 10'h0};
        end else if (inf2 || zero1) begin
            spec_res   = {sign_r, 15'h0};
        end else begin
            special    = 1'b0;
        end
    end

    // Rounding: denormalising shift for tiny exponents, then RNE on guard/round/sticky
    logic                 tiny, g_bit, r_bit, sticky, round_up, nx;
    logic [EW-1:0]        shamt;
    logic [QBITS-1:0]     q_sh, lost_mask;
    logic [FRACW+1:0]     mant_r;
    logic signed [EW-1:0] e_fin;
    logic [15:0]          rnd_res;
    logic [4:0]           rnd_flags;

    always_comb begin
        tiny      = exp_q <= 0;
        shamt     = tiny ? EW'(BIAS_S - BIAS_S + 1 - exp_q) : '0;
        q_sh      = quo_q;
        sticky    = |rem_q;
        lost_mask = '0;
        if (tiny) begin
            if (shamt >= EW'(QBITS)) begin
                q_sh   = '0;
                sticky = 1'b1;
            end else begin
                lost_mask = (QBITS'(1) << shamt) - QBITS'(1);
                sticky    = sticky | (|(quo_q & lost_mask));
                q_sh      = quo_q >> shamt;
            end
        end
        g_bit    = q_sh[1];
        r_bit    = q_sh[0];
        round_up = g_bit & (r_bit | sticky | q_sh[2]);
        mant_r   = {1'b0, q_sh[QBITS-1:2]} + {{(FRACW+1){1'b0}}, round_up};
        e_fin    = exp_q + $signed({{(EW-1){1'b0}}, mant_r[FRACW+1]});
        nx       = g_bit | r_bit | sticky;
        if (tiny) begin
            // A subnormal rounding into bit 10 lands exactly on the minimum normal
            rnd_res   = {sign_r, 4'b0, mant_r[FRACW:0]};
            rnd_flags = {2'b00, 1'b0, 1'b0, nx};
        end else if (e_fin >= 31) begin
            rnd_res   = {sign_r, 5'h1F, 10'h0};
            rnd_flags = 5'b00101;
        end else begin
            rnd_res   = {sign_r, e_fin[EXPW-1:0], mant_r[FRACW-1:0]};
            rnd_flags = {2'b00, 1'b0, 1'b0, nx};
        end
        rnd_flags[1] = (rnd_res[14:10] == 5'd0) && nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_PREP;
            S_PREP: begin
                if (special)                       state_d = S_DONE;
                else if (sig1_q[FRACW] && sig2_q[FRACW]) state_d = S_DIVIDE;
            end
            S_DIVIDE: if (cnt_q == 4'(QBITS - 2)) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    logic                 lt;
    logic [FRACW+1:0]     num;
    logic [FRACW+2:0]     diff;

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no branch infers a latch.
        a_d = a_q;  b_d = b_q;  sig1_d = sig1_q;  sig2_d = sig2_q;
        ex1_d = ex1_q;  ex2_d = ex2_q;  exp_d = exp_q;
        rem_d = rem_q;  quo_d = quo_q;  cnt_d = cnt_q;
        out_d = out_q;  flags_d = flags_q;  cc_d = cc_q;
        lt   = sig1_q < sig2_q;
        num  = lt ? {sig1_q, 1'b0} : {1'b0, sig1_q};
        diff = {1'b0, rem_q} - {2'b00, sig2_q};
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                a_d    = fpuIn1;
                b_d    = fpuIn2;
                sig1_d = {|fpuIn1[14:10], fpuIn1[9:0]};
                sig2_d = {|fpuIn2[14:10], fpuIn2[9:0]};
                ex1_d  = (|fpuIn1[14:10]) ? $signed({3'b000, fpuIn1[14:10]}) : 8'sd1;
                ex2_d  = (|fpuIn2[14:10]) ? $signed({3'b000, fpuIn2[14:10]}) : 8'sd1;
            end
            S_PREP: begin
                if (special) begin
                    out_d   = spec_res;
                    flags_d = spec_flags;
                    cc_d    = cc_of(spec_res);
                end else if (!sig1_q[FRACW]) begin
                    sig1_d = sig1_q << 1;
                    ex1_d  = ex1_q - 8'sd1;
                end else if (!sig2_q[FRACW]) begin
                    sig2_d = sig2_q << 1;
                    ex2_d  = ex2_q - 8'sd1;
                end else begin
                    // Aligned dividend always yields a leading 1, so the first quotient bit is taken here
                    exp_d = ex1_q - ex2_q + BIAS_S - $signed({{(EW-1){1'b0}}, lt});
                    rem_d = (num - {1'b0, sig2_q}) << 1;
                    quo_d = QBITS'(1);
                    cnt_d = '0;
                end
            end
            S_DIVIDE: begin
                rem_d = (diff[FRACW+2] ? rem_q : diff[FRACW+1:0]) << 1;
                quo_d = {quo_q[QBITS-2:0], !diff[FRACW+2]};
                cnt_d = cnt_q + 4'd1;
            end
            S_ROUND: begin
                out_d   = rnd_res;
                flags_d = rnd_flags;
                cc_d    = cc_of(rnd_res);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q <= '0;  b_q <= '0;  sig1_q <= '0;  sig2_q <= '0;
            ex1_q <= '0;  ex2_q <= '0;  exp_q <= '0;
            rem_q <= '0;  quo_q <= '0;  cnt_q <= '0;
            out_q <= '0;  flags_q <= '0;  cc_q <= '0;
        end else begin
            a_q <= a_d;  b_q <= b_d;  sig1_q <= sig1_d;  sig2_q <= sig2_d;
            ex1_q <= ex1_d;  ex2_q <= ex2_d;  exp_q <= exp_d;
            rem_q <= rem_d;  quo_q <= quo_d;  cnt_q <= cnt_d;
            out_q <= out_d;  flags_q <= flags_d;  cc_q <= cc_d;
        end
    end

    always_comb begin
        done          = state_q == S_DONE;
        fpuOut        = out_q;
        condCodes     = cc_q;
        opStatusFlags = flags_q;
    end
endmodule

// File: tb/tb_fpu_div16.sv
// Directed bench for fpu_div16: hand-computed quotients, flags, condition codes and latencies.
module tb_fpu_div16;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] fpuIn1 = '0;
    logic [15:0] fpuIn2 = '0;
    logic [15:0] fpuOut;
    logic        done;
    logic [3:0]  condCodes;
    logic [4:0]  opStatusFlags;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    fpu_div16 dut (
        .clock(clock), .reset(reset), .start(start),
        .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOut(fpuOut),
        .done(done), .condCodes(condCodes), .opStatusFlags(opStatusFlags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; the launch edge counts as edge 1
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold,
                          output int edges);
        fpuIn1 = a;
        fpuIn2 = b;
        start  = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clock); #1;
            edges++;
        end
    endtask

    task automatic expect_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] eo, input logic [4:0] ef, input logic [3:0] ec,
                             input int elat, input bit hold);
        int edges;
        run_op(a, b, hold, edges);
        check({tag, "/done"},  32'(done), 32'd1);
        check({tag, "/out"},   32'(fpuOut), 32'(eo));
        check({tag, "/flags"}, 32'(opStatusFlags), 32'(ef));
        check({tag, "/cc"},    32'(condCodes), 32'(ec));
        if (elat > 0) check({tag, "/latency"}, 32'(edges), 32'(elat));
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset/done",  32'(done), 32'd0);
        check("reset/out",   32'(fpuOut), 32'd0);
        check("reset/cc",    32'(condCodes), 32'd0);
        check("reset/flags", 32'(opStatusFlags), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        expect_op("div_6_2",      16'h4600, 16'h4000, 16'h4200, 5'b00000, 4'b0000, 15, 1'b0);
        expect_op("div_1_3",      16'h3C00, 16'h4200, 16'h3555, 5'b00001, 4'b0000, 15, 1'b0);
        expect_op("div_m1_3",     16'hBC00, 16'h4200, 16'hB555, 5'b00001, 4'b0010, 15, 1'b0);
        expect_op("div_5_3_rne",  16'h4500, 16'h4200, 16'h3EAB, 5'b00001, 4'b0000, 15, 1'b0);
        expect_op("div_by_zero",  16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 4'b0000, 2, 1'b0);
        expect_op("zero_zero",    16'h0000, 16'h0000, 16'h7E00, 5'b10000, 4'b0000, 2, 1'b0);
        expect_op("inf_inf",      16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 4'b0000, 2, 1'b0);
        expect_op("nan_in",       16'h3C00, 16'h7C01, 16'h7E00, 5'b10000, 4'b0000, 2, 1'b0);
        expect_op("inf_fin",      16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 4'b0010, 2, 1'b0);
        expect_op("negzero_fin",  16'h8000, 16'h4000, 16'h8000, 5'b00000, 4'b1010, 2, 1'b0);
        expect_op("fin_inf",      16'h3C00, 16'h7C00, 16'h0000, 5'b00000, 4'b1000, 2, 1'b0);
        expect_op("overflow",     16'h7BFF, 16'h1400, 16'h7C00, 5'b00101, 4'b0000, 15, 1'b0);
        expect_op("underflow",    16'h0001, 16'h7BFF, 16'h0000, 5'b00011, 4'b1000, 25, 1'b0);
        expect_op("exact_sub",    16'h0400, 16'h4000, 16'h0200, 5'b00000, 4'b0000, 15, 1'b0);
        expect_op("sub_in",       16'h0200, 16'h0400, 16'h3800, 5'b00000, 4'b0000, 16, 1'b0);
        expect_op("sub_to_norm",  16'h07FF, 16'h4000, 16'h0400, 5'b00001, 4'b0000, 15, 1'b0);

        // Reset in the middle of DIVIDE must abort without a done
        fpuIn1 = 16'h4600;
        fpuIn2 = 16'h4000;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_reset/done",  32'(done), 32'd0);
        check("mid_reset/out",   32'(fpuOut), 32'd0);
        check("mid_reset/cc",    32'(condCodes), 32'd0);
        check("mid_reset/flags", 32'(opStatusFlags), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done) seen = 1;
        end
        check("mid_reset/no_done", 32'(seen), 32'd0);
        expect_op("restart_6_2",  16'h4600, 16'h4000, 16'h4200, 5'b00000, 4'b0000, 15, 1'b0);

        // start held high through DONE relaunches back to back
        expect_op("b2b_1", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 4'b0000, 15, 1'b1);
        expect_op("b2b_2", 16'h4500, 16'h4200, 16'h3EAB, 5'b00001, 4'b0000, 15, 1'b1);
        expect_op("b2b_3", 16'h4600, 16'h4000, 16'h4200, 5'b00000, 4'b0000, 15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
